// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
//   sram_req_t : one requester's access fields at the default geometry.
//   rr_next()  : round-robin pointer advance with wrap.
package sram_arb_pkg;

    localparam int SramAwDef = 12;
    localparam int SramDwDef = 32;

    typedef struct packed {
        logic                   we;
        logic [SramAwDef-1:0]   addr;
        logic [SramDwDef-1:0]   wdata;
        logic [SramDwDef/8-1:0] wmask;
    } sram_req_t;

    // Next pointer after granting index cur out of num requesters.
    // Wraps from num-1 back to 0. A single requester always stays at 0.
    function automatic int rr_next(input int cur, input int num);
        int nxt;
        if (num <= 1) begin
            nxt = 0;
        end else if (cur >= num - 1) begin
            nxt = 0;
        end else begin
            nxt = cur + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// N-way round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : per-requester request
//   gnt_o        : one-hot grant (combinational on req_i)
//   idx_o        : index of the granted requester
//   valid_o      : any grant this cycle
// The search starts at the pointer and wraps; the pointer moves to the
// slot after the winner on every granted cycle and holds otherwise.
module sram_rr_arb
    import sram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N-1:0]                         req_i,
    output logic [N-1:0]                         gnt_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
    output logic                                 valid_o
);

    localparam int IdxW = (N > 1) ? $clog2(N) : 1;

    logic [IdxW-1:0] ptr_r;

    // Winner search: first set request at or after the pointer, with wrap.
    always_comb begin
        int              cand;
        logic [IdxW-1:0] cand_idx;
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand     = (int'(ptr_r) + i) % N;
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

    // Pointer register: advance past the winner on a grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= '0;
        end else if (valid_o) begin
            ptr_r <= IdxW'(rr_next(int'(idx_o), N));
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between NumReq requesters.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/wmask_i : per-requester access fields
//   gnt_o                : one-hot grant, same cycle as the access
//   rvalid_o, rdata_o    : read response routed to the issuing requester
//   csb_o, we_o          : SRAM chip select / write enable, active-low
//   addr_o, wdata_o, wmask_o : SRAM address, write data, byte mask
//   rdata_i              : SRAM read data, one cycle after the read
// Build option SRAM_ARB_RDATA_REG_EN: registers rdata_i and adds one more
// response stage, giving read latency 2 instead of 1.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int SramAw = SramAwDef,
    parameter int SramDw = SramDwDef
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     req_i,
    input  logic [NumReq-1:0]                     we_i,
    input  logic [NumReq-1:0][SramAw-1:0]         addr_i,
    input  logic [NumReq-1:0][SramDw-1:0]         wdata_i,
    input  logic [NumReq-1:0][SramDw/8-1:0]       wmask_i,
    output logic [NumReq-1:0]                     gnt_o,
    output logic [NumReq-1:0]                     rvalid_o,
    output logic [SramDw-1:0]                     rdata_o,
    output logic                                  csb_o,
    output logic                                  we_o,
    output logic [SramAw-1:0]                     addr_o,
    output logic [SramDw-1:0]                     wdata_o,
    output logic [SramDw/8-1:0]                   wmask_o,
    input  logic [SramDw-1:0]                     rdata_i
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0] req_s;
    logic [NumReq-1:0] gnt_s;
    logic [IdxW-1:0]   win_s;
    logic              win_valid_s;
    logic              rd_fire_s;

    logic              rd_v1_r;
    logic [IdxW-1:0]   rd_id1_r;

    logic              rsp_v_s;
    logic [IdxW-1:0]   rsp_id_s;
    logic [SramDw-1:0] rsp_data_s;

    // Requests are masked during reset so nothing is granted or driven.
    assign req_s = rst_i ? '0 : req_i;

    sram_rr_arb #(
        .N (NumReq)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_s),
        .gnt_o   (gnt_s),
        .idx_o   (win_s),
        .valid_o (win_valid_s)
    );

    assign gnt_o     = gnt_s;
    assign rd_fire_s = win_valid_s & ~we_i[win_s];

    // SRAM pin drive from the winner; idle pins are deselected and zeroed.
    always_comb begin
        csb_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = '0;
        wdata_o = '0;
        wmask_o = '0;
        if (win_valid_s) begin
            csb_o   = 1'b0;
            we_o    = ~we_i[win_s];
            addr_o  = addr_i[win_s];
            wdata_o = wdata_i[win_s];
            wmask_o = wmask_i[win_s];
        end else begin
            csb_o = 1'b1;
        end
    end

    // First response stage: remembers who issued the read last cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_v1_r  <= 1'b0;
            rd_id1_r <= '0;
        end else begin
            rd_v1_r  <= rd_fire_s;
            rd_id1_r <= win_s;
        end
    end

`ifdef SRAM_ARB_RDATA_REG_EN
    logic              rd_v2_r;
    logic [IdxW-1:0]   rd_id2_r;
    logic [SramDw-1:0] rdata_r;

    // Second response stage: captures the macro data alongside its owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_v2_r  <= 1'b0;
            rd_id2_r <= '0;
            rdata_r  <= '0;
        end else begin
            rd_v2_r  <= rd_v1_r;
            rd_id2_r <= rd_id1_r;
            rdata_r  <= rd_v1_r ? rdata_i : '0;
        end
    end

    assign rsp_v_s    = rd_v2_r;
    assign rsp_id_s   = rd_id2_r;
    assign rsp_data_s = rdata_r;
`else
    assign rsp_v_s    = rd_v1_r;
    assign rsp_id_s   = rd_id1_r;
    assign rsp_data_s = rdata_i;
`endif

    // Response routing; suppressed during reset so a read caught by reset
    // never surfaces, and data is zero whenever no valid is raised.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (rsp_v_s && !rst_i) begin
            rvalid_o[rsp_id_s] = 1'b1;
            rdata_o            = rsp_data_s;
        end else begin
            rdata_o = '0;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter (NumReq=2, 12-bit addr, 32-bit data).
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_RDATA_REG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = 2'b11;
    logic [1:0]       we  = 2'b00;
    logic [1:0][11:0] addr  = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][3:0]  wmask = '0;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [31:0]      rdata;
    logic             csb;
    logic             sram_we;
    logic [11:0]      sram_addr;
    logic [31:0]      sram_wdata;
    logic [3:0]       sram_wmask;
    logic [31:0]      sram_rdata = 32'h0;

    logic [31:0] mem [4096];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q[$];

    sram_port_arbiter #(.NumReq(2), .SramAw(12), .SramDw(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .wmask_i  (wmask),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .csb_o    (csb),
        .we_o     (sram_we),
        .addr_o   (sram_addr),
        .wdata_o  (sram_wdata),
        .wmask_o  (sram_wmask),
        .rdata_i  (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM with byte mask and one-cycle read.
    always @(posedge clk) begin
        logic [31:0] tmp;
        if (!csb) begin
            if (!sram_we) begin
                tmp = mem[sram_addr];
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask[b]) tmp[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                mem[sram_addr] <= tmp;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missing_rvalid", 64'(q[0].cyc), 64'(cyc));
                void'(q.pop_front());
            end
            if (rvalid != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", {62'h0, rvalid}, 64'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rvalid_owner", {62'h0, rvalid}, 64'(2'b01 << e.id));
                    chk("rdata", {32'h0, rdata}, {32'h0, e.data});
                    chk("rsp_latency", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("rdata_idle_zero", {32'h0, rdata}, 64'h0);
            end
        end
    end

    task automatic push(input int id, input logic [31:0] d);
        exp_t e;
        e.id = id; e.data = d; e.cyc = cyc + Lat;
        q.push_back(e);
    endtask

    // Apply one cycle of stimulus just after the edge, return at the negedge.
    task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w,
                         input logic [11:0] a0, input logic [11:0] a1,
                         input logic [31:0] d1, input logic [3:0] m1);
        @(posedge clk);
        #1;
        rst = r; req = rq; we = w;
        addr[0] = a0; addr[1] = a1;
        wdata[0] = 32'h0; wdata[1] = d1;
        wmask[0] = 4'h0;  wmask[1] = m1;
        @(negedge clk);
    endtask

    task automatic chk_bus(input string nm, input logic [1:0] g, input logic c,
                           input logic w, input logic [11:0] a);
        chk({nm, "_gnt"}, {62'h0, gnt}, {62'h0, g});
        chk({nm, "_csb"}, {63'h0, csb}, {63'h0, c});
        chk({nm, "_we"},  {63'h0, sram_we}, {63'h0, w});
        chk({nm, "_addr"}, {52'h0, sram_addr}, {52'h0, a});
    endtask

    initial begin
        logic [11:0] a0;
        logic [11:0] a1;
        int          w;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
        mem[12'h010] = 32'hDEAD_BEEF;
        mem[12'h0A5] = 32'hFFFF_FFFF;

        // Reset with both requesters asserted: nothing may be granted.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 2'b00, 12'h001, 12'h002, 32'h0, 4'h0);
            chk_bus("reset", 2'b00, 1'b1, 1'b1, 12'h000);
            chk("reset_rvalid", {62'h0, rvalid}, 64'h0);
            chk("reset_rdata", {32'h0, rdata}, 64'h0);
        end
        mon_on = 1'b1;

        // Single read by requester 0.
        drive(1'b0, 2'b01, 2'b00, 12'h010, 12'h000, 32'h0, 4'h0);
        chk_bus("single_read", 2'b01, 1'b0, 1'b1, 12'h010);
        push(0, 32'hDEAD_BEEF);

        // Byte-masked write by requester 1 directly behind the read.
        drive(1'b0, 2'b10, 2'b10, 12'h000, 12'h0A5, 32'h1122_3344, 4'b0101);
        chk_bus("byte_write", 2'b10, 1'b0, 1'b0, 12'h0A5);
        chk("byte_write_wmask", {60'h0, sram_wmask}, 64'h5);
        chk("byte_write_wdata", {32'h0, sram_wdata}, 64'h1122_3344);

        // Read back the merged word.
        drive(1'b0, 2'b10, 2'b00, 12'h000, 12'h0A5, 32'h0, 4'h0);
        chk_bus("readback", 2'b10, 1'b0, 1'b1, 12'h0A5);
        push(1, 32'hFF22_FF44);

        // Idle: pins deselected and zero.
        drive(1'b0, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 4'h0);
        chk_bus("idle", 2'b00, 1'b1, 1'b1, 12'h000);
        drive(1'b0, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 4'h0);

        // Fresh reset then continuous contention: grants alternate from req0.
        drive(1'b1, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 4'h0);
        for (int t = 0; t < 8; t++) begin
            a0 = 12'h100 + 12'((t + 1) / 2);
            a1 = 12'h200 + 12'(t / 2);
            w  = t % 2;
            drive(1'b0, 2'b11, 2'b00, a0, a1, 32'h0, 4'h0);
            chk_bus("fair", (w == 1) ? 2'b10 : 2'b01, 1'b0, 1'b1, (w == 1) ? a1 : a0);
            push(w, 32'h1000_0000 + 32'((w == 1) ? a1 : a0));
        end

        // Read granted, then reset in the next cycle: the read never returns.
        drive(1'b0, 2'b01, 2'b00, 12'h020, 12'h000, 32'h0, 4'h0);
        chk_bus("pre_reset_read", 2'b01, 1'b0, 1'b1, 12'h020);
        drive(1'b1, 2'b01, 2'b00, 12'h020, 12'h000, 32'h0, 4'h0);
        chk_bus("mid_reset", 2'b00, 1'b1, 1'b1, 12'h000);
        chk("mid_reset_rvalid", {62'h0, rvalid}, 64'h0);

        // Pointer must be back at 0: contention goes to requester 0 first.
        drive(1'b0, 2'b11, 2'b00, 12'h030, 12'h040, 32'h0, 4'h0);
        chk_bus("post_reset_ptr", 2'b01, 1'b0, 1'b1, 12'h030);
        push(0, 32'h1000_0030);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0, 4'h0);
        end
        chk("scoreboard_drained", 64'(q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port data-memory SRAM macro between NumReq requesters, e.g. the TL-UL SRAM adapter and a DMA or debug port.
- Arbitrates round-robin, one access per cycle, and drives the macro pins directly: active-low chip select, active-low write enable, byte mask.
- Routes the fixed-latency read data back to the requester that issued the read, with a per-requester valid.

Parameters:
- NumReq, 2, number of requesters (1..8).
- SramAw, 12, SRAM word-address width.
- SramDw, 32, SRAM data width; byte-mask width is SramDw/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; synchronous, active-high.
- req_i  in  NumReq  per-requester access request.
- we_i  in  NumReq  per-requester write (1=write, 0=read).
- addr_i  in  NumReq x SramAw  word address.
- wdata_i  in  NumReq x SramDw  write data.
- wmask_i  in  NumReq x SramDw/8  byte enables.
- gnt_o  out  NumReq  one-hot grant, same cycle as the accepted request.
- rvalid_o  out  NumReq  read-data valid for the issuing requester.
- rdata_o  out  SramDw  shared read data, qualified by rvalid_o.
- csb_o  out  1  SRAM chip select, active-low.
- we_o  out  1  SRAM write enable, active-low (0=write).
- addr_o  out  SramAw  SRAM address.
- wdata_o  out  SramDw  SRAM write data.
- wmask_o  out  SramDw/8  SRAM byte mask.
- rdata_i  in  SramDw  SRAM read data, valid one cycle after a read.

Behaviour:
- Reset values (rst_i high at a posedge):
  - rr pointer = 0; all rvalid_o = 0; response-pipe winner id = 0.
  - While rst_i is high: csb_o = 1, we_o = 1, gnt_o = 0, rdata_o = 0.
- Arbitration is combinational on req_i.
  - The winner is the first requester with req_i set, searching from the pointer upward with wrap (index NumReq-1 -> 0).
  - gnt_o is one-hot on the winner. No request -> gnt_o = 0, csb_o = 1.
- Pointer update: at a posedge with a grant, pointer <= winner+1, wrapping to 0 after NumReq-1. No grant -> pointer holds.
- Granted cycle SRAM drive:
  - csb_o = 0, we_o = ~we_i[w].
  - addr_o, wdata_o, wmask_o from the winner.
  - When not granted, these three outputs are 0.
- Requester contract:
  - Hold req and its fields stable until gnt is seen; drop or change them the cycle after.
  - Back-to-back requests from the same requester are allowed.
- Read response, macro disabled:
  - A read granted in cycle T gives rvalid_o[w] = 1 in cycle T+1, with rdata_o = rdata_i.
  - rdata_o = 0 whenever no rvalid_o is set.
- Writes produce no rvalid; completion is implied by the grant.
- Throughput: one access per cycle sustained. A read and a write from different requesters in consecutive cycles must not disturb the read response.
- Fairness: with all requesters continuously requesting, each is granted exactly once every NumReq cycles.
- Reset mid-operation: a read granted in the cycle rst_i is sampled gets no rvalid; pending pipe state is cleared.
- NumReq = 1:
  - Pointer is 1 bit and held at 0.
  - gnt_o = req_i.
  - Must elaborate without zero-width signals.
- Only one rvalid_o bit may ever be set in any cycle.

Optional Feature:
- Macro: SRAM_ARB_RDATA_REG_EN.
- Defined:
  - rdata_i is captured in a register, and the winner id / read flag is delayed one more stage.
  - A read granted in cycle T gives rvalid_o in cycle T+2, with registered rdata_o (0 when not valid).
  - Throughput is still one per cycle; two reads in flight must stay ordered.
  - Reset clears both stages.
- Undefined: latency 1 as described in Behaviour; no rdata register.

Decomposition:
- Package sram_arb_pkg:
  - sram_req_t struct {we, addr, wdata, wmask}, sized by package constants SramAwDef = 12 and SramDwDef = 32.
  - Function rr_next() for pointer wrap.
- Sub-module sram_rr_arb: round-robin pointer register plus one-hot winner and index generation; reused elsewhere for NumReq-way arbitration.

Test Plan:
- Reset and idle: rst_i high for 3 cycles with req_i = 2'b11 -> gnt_o = 0, csb_o = 1, we_o = 1, rvalid_o = 0 throughout.
- Single read: req0 read addr 0x010, SRAM model holds 0xDEADBEEF -> gnt_o = 2'b01 and csb_o = 0, we_o = 1, addr_o = 0x010 in cycle T; rvalid_o = 2'b01 and rdata_o = 0xDEADBEEF at T+1 (T+2 with the macro).
- Byte write then read: req1 writes 0x0A5 with wdata 0x11223344, wmask 4'b0101 over 0xFFFFFFFF -> we_o = 0, wmask_o = 4'b0101; a later read returns 0xFF22FF44 with rvalid_o = 2'b10 only.
- Contention fairness: both requesters read continuously for 8 cycles from reset -> grants alternate 01,10,01,10,...; each rvalid matches the prior-cycle grant and the data addressed.
- Mixed back-to-back: req0 reads A in cycle T, req1 writes B in T+1 -> rvalid_o[0] only at T+1 with the correct data; no rvalid for the write.
- Reset mid-read: assert rst_i in the cycle a read is granted -> no rvalid_o in any following cycle; pointer = 0 afterwards.
